// File: rtl/bst_cmd_interface_pkg.sv
// Shared definitions for the BST command front-end: opcodes, status codes,
// FSM states and the bit offsets of the command/completion beat fields.
package bster_pkg;

  localparam logic [7:0] OP_INSERT = 8'h01;
  localparam logic [7:0] OP_SEARCH = 8'h02;
  localparam logic [7:0] OP_DELETE = 8'h03;

  localparam logic [7:0] STAT_OK          = 8'h00;
  localparam logic [7:0] STAT_ILLEGAL_CMD = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_CPL,
    ST_SEND_CPL
  } state_t;

  // Both beats share one layout: [7:0] code, then token, then payload.
  localparam int FLD_CODE_LSB = 0;
  localparam int FLD_TOK_LSB  = 8;

  function automatic int fld_data_lsb(int tw);
    return FLD_TOK_LSB + tw;
  endfunction

  function automatic int fld_total(int tw, int pw);
    return FLD_TOK_LSB + tw + pw;
  endfunction

  function automatic logic op_is_legal(logic [7:0] op);
    return (op == OP_INSERT) || (op == OP_SEARCH) || (op == OP_DELETE);
  endfunction

endpackage

// File: rtl/bst_cmd_interface_if.sv
// Handshake bundle between the host/engine side and the command front-end.
// slave = the front-end itself, master = whatever drives it.
interface bst_cmd_interface_if #(
  parameter int TOKEN_WIDTH   = 8,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int AXI4S_WIDTH   = 128
);
  logic                     cmd_tvalid;
  logic                     cmd_tready;
  logic [AXI4S_WIDTH-1:0]   cmd_tdata;

  logic                     itf_valid;
  logic                     itf_ready;
  logic [7:0]               itf_cmd;
  logic [TOKEN_WIDTH-1:0]   itf_token;
  logic [PAYLOAD_WIDTH-1:0] itf_data;

  logic                     eng_cpl_valid;
  logic                     eng_cpl_ready;
  logic [7:0]               eng_cpl_status;
  logic [TOKEN_WIDTH-1:0]   eng_cpl_token;
  logic [PAYLOAD_WIDTH-1:0] eng_cpl_data;

  logic                     cpl_tvalid;
  logic                     cpl_tready;
  logic [AXI4S_WIDTH-1:0]   cpl_tdata;

  modport slave (
    input  cmd_tvalid, cmd_tdata, itf_ready,
           eng_cpl_valid, eng_cpl_status, eng_cpl_token, eng_cpl_data,
           cpl_tready,
    output cmd_tready, itf_valid, itf_cmd, itf_token, itf_data,
           eng_cpl_ready, cpl_tvalid, cpl_tdata
  );

  modport master (
    output cmd_tvalid, cmd_tdata, itf_ready,
           eng_cpl_valid, eng_cpl_status, eng_cpl_token, eng_cpl_data,
           cpl_tready,
    input  cmd_tready, itf_valid, itf_cmd, itf_token, itf_data,
           eng_cpl_ready, cpl_tvalid, cpl_tdata
  );
endinterface

// File: rtl/bst_cmd_interface.sv
// BST command front-end: takes one AXI4-Stream command beat, rejects illegal
// opcodes locally, forwards legal ones to the engine and returns the engine
// completion as one AXI4-Stream beat. One command in flight at a time.
// Every output is a decode of registered state, so no input reaches an
// output combinationally.
module bst_cmd_interface
  import bster_pkg::*;
#(
  parameter int TOKEN_WIDTH   = 8,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int AXI4S_WIDTH   = 128
) (
  input  logic aclk,
  input  logic aresetn,   // active-high synchronous reset despite the name
  bst_cmd_interface_if.slave bus
);

  localparam int DATA_LSB   = fld_data_lsb(TOKEN_WIDTH);
  localparam int FIELD_BITS = fld_total(TOKEN_WIDTH, PAYLOAD_WIDTH);

  if (FIELD_BITS > AXI4S_WIDTH) begin : g_width_check
    $error("bst_cmd_interface: TOKEN_WIDTH+PAYLOAD_WIDTH+8 exceeds AXI4S_WIDTH");
  end

  // Command bits above the packed fields carry nothing for us.
  if (FIELD_BITS < AXI4S_WIDTH) begin : g_hi_unused
    logic w_unused_hi;
    assign w_unused_hi = ^bus.cmd_tdata[AXI4S_WIDTH-1:FIELD_BITS];
  end

  state_t                   r_state;
  state_t                   w_next_state;

  logic [7:0]               r_op;
  logic [TOKEN_WIDTH-1:0]   r_tok;
  logic [PAYLOAD_WIDTH-1:0] r_pay;

  logic [7:0]               r_cpl_st;
  logic [TOKEN_WIDTH-1:0]   r_cpl_tok;
  logic [PAYLOAD_WIDTH-1:0] r_cpl_data;

  logic [7:0]               w_in_op;
  logic [TOKEN_WIDTH-1:0]   w_in_tok;
  logic [PAYLOAD_WIDTH-1:0] w_in_pay;
  logic                     w_cmd_hs;
  logic                     w_eng_hs;

  assign w_in_op  = bus.cmd_tdata[FLD_CODE_LSB +: 8];
  assign w_in_tok = bus.cmd_tdata[FLD_TOK_LSB +: TOKEN_WIDTH];
  assign w_in_pay = bus.cmd_tdata[DATA_LSB +: PAYLOAD_WIDTH];
  assign w_cmd_hs = (r_state == ST_IDLE) && bus.cmd_tvalid;
  assign w_eng_hs = (r_state == ST_WAIT_CPL) && bus.eng_cpl_valid;

  // State register; reset drops any in-flight command or completion.
  always_ff @(posedge aclk) begin
    if (aresetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state decode; an illegal opcode skips the engine entirely.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:     if (bus.cmd_tvalid)
                     w_next_state = op_is_legal(w_in_op) ? ST_ISSUE : ST_SEND_CPL;
      ST_ISSUE:    if (bus.itf_ready)     w_next_state = ST_WAIT_CPL;
      ST_WAIT_CPL: if (bus.eng_cpl_valid) w_next_state = ST_SEND_CPL;
      ST_SEND_CPL: if (bus.cpl_tready)    w_next_state = ST_IDLE;
      default:                            w_next_state = ST_IDLE;
    endcase
  end

  // Capture command fields on acceptance; these drive the engine request.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      r_op  <= '0;
      r_tok <= '0;
      r_pay <= '0;
    end else if (w_cmd_hs) begin
      r_op  <= w_in_op;
      r_tok <= w_in_tok;
      r_pay <= w_in_pay;
    end
  end

  // Completion register: local ILLEGAL_CMD on a bad opcode, else engine result.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      r_cpl_st   <= '0;
      r_cpl_tok  <= '0;
      r_cpl_data <= '0;
    end else if (w_cmd_hs && !op_is_legal(w_in_op)) begin
      r_cpl_st   <= STAT_ILLEGAL_CMD;
      r_cpl_tok  <= w_in_tok;
      r_cpl_data <= '0;
    end else if (w_eng_hs) begin
      r_cpl_st   <= bus.eng_cpl_status;
      r_cpl_tok  <= bus.eng_cpl_token;
      r_cpl_data <= bus.eng_cpl_data;
    end
  end

  // Output decode from registered state only; unused completion bits stay 0.
  always_comb begin
    bus.cmd_tready    = (r_state == ST_IDLE);
    bus.itf_valid     = (r_state == ST_ISSUE);
    bus.eng_cpl_ready = (r_state == ST_WAIT_CPL);
    bus.cpl_tvalid    = (r_state == ST_SEND_CPL);
    bus.itf_cmd       = r_op;
    bus.itf_token     = r_tok;
    bus.itf_data      = r_pay;
    bus.cpl_tdata     = '0;
    bus.cpl_tdata[FLD_CODE_LSB +: 8]         = r_cpl_st;
    bus.cpl_tdata[FLD_TOK_LSB +: TOKEN_WIDTH] = r_cpl_tok;
    bus.cpl_tdata[DATA_LSB +: PAYLOAD_WIDTH]  = r_cpl_data;
  end

endmodule

// File: tb/tb_bst_cmd_interface.sv
// Bench for bst_cmd_interface: vector table driven through full command /
// completion transactions with a completion scoreboard, plus hand sequences
// for reset, back-to-back commands and reset while waiting on the engine.
module tb_bst_cmd_interface;
  logic aclk;
  logic aresetn;

  bst_cmd_interface_if #(.TOKEN_WIDTH(8), .PAYLOAD_WIDTH(32), .AXI4S_WIDTH(128)) bus ();

  bst_cmd_interface #(.TOKEN_WIDTH(8), .PAYLOAD_WIDTH(32), .AXI4S_WIDTH(128)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [127:0] sb_q[$];

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  tok;
    logic [31:0] pay;
    logic [7:0]  eng_st;
    logic [7:0]  eng_tok;
    logic [31:0] eng_data;
    int          istall;
    int          cstall;
    bit          exp_fwd;   // expected to reach the engine
    logic [7:0]  exp_st;    // expected completion status
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] pack3(logic [7:0] c, logic [7:0] t, logic [31:0] d);
    logic [127:0] r;
    r = '0;
    r[7:0]   = c;
    r[15:8]  = t;
    r[47:16] = d;
    return r;
  endfunction

  // Offer one command from IDLE; illegal opcodes queue their completion here.
  task automatic send_cmd(input logic [7:0] op, input logic [7:0] tok, input logic [31:0] pay,
                          input bit fwd);
    chk("cmd_tready_idle", bus.cmd_tready, 1);
    bus.cmd_tvalid = 1'b1;
    bus.cmd_tdata  = pack3(op, tok, pay);
    if (!fwd) sb_q.push_back(pack3(8'h80, tok, 32'h0));
    tick();
    bus.cmd_tvalid = 1'b0;
    bus.cmd_tdata  = '0;
  endtask

  // Check the engine request, hold it off for some cycles, then accept it.
  task automatic issue_accept(input logic [7:0] op, input logic [7:0] tok, input logic [31:0] pay,
                              input int stall);
    for (int k = 0; k <= stall; k++) begin
      chk("itf_valid", bus.itf_valid, 1);
      chk("itf_cmd", bus.itf_cmd, op);
      chk("itf_token", bus.itf_token, tok);
      chk("itf_data", bus.itf_data, pay);
      chk("cmd_tready_busy", bus.cmd_tready, 0);
      if (k < stall) tick();
    end
    bus.itf_ready = 1'b1;
    tick();
    bus.itf_ready = 1'b0;
  endtask

  task automatic eng_complete(input logic [7:0] st, input logic [7:0] tok, input logic [31:0] d);
    chk("eng_cpl_ready", bus.eng_cpl_ready, 1);
    chk("itf_valid_after", bus.itf_valid, 0);
    bus.eng_cpl_valid  = 1'b1;
    bus.eng_cpl_status = st;
    bus.eng_cpl_token  = tok;
    bus.eng_cpl_data   = d;
    sb_q.push_back(pack3(st, tok, d));
    tick();
    bus.eng_cpl_valid = 1'b0;
  endtask

  // Wait (bounded) for a completion, hold it, then take it and compare.
  task automatic recv_cpl(input int stall);
    logic [127:0] e;
    int n;
    n = 0;
    while (!bus.cpl_tvalid && n < 4) begin
      tick();
      n++;
    end
    chk("cpl_tvalid", bus.cpl_tvalid, 1);
    chk("sb_nonempty", sb_q.size() != 0, 1);
    if (sb_q.size() == 0) return;
    e = sb_q[0];
    for (int k = 0; k < stall; k++) begin
      chk("cpl_hold_data", bus.cpl_tdata, e);
      chk("cpl_hold_valid", bus.cpl_tvalid, 1);
      chk("cmd_tready_send", bus.cmd_tready, 0);
      tick();
    end
    bus.cpl_tready = 1'b1;
    chk("cpl_tdata", bus.cpl_tdata, e);
    void'(sb_q.pop_front());
    tick();
    bus.cpl_tready = 1'b0;
    chk("cpl_tvalid_drop", bus.cpl_tvalid, 0);
    chk("cmd_tready_back", bus.cmd_tready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    send_cmd(v.op, v.tok, v.pay, v.exp_fwd);
    if (v.exp_fwd) begin
      issue_accept(v.op, v.tok, v.pay, v.istall);
      eng_complete(v.eng_st, v.eng_tok, v.eng_data);
    end else begin
      chk("itf_valid_illegal", bus.itf_valid, 0);
      chk("cpl_status_illegal", bus.cpl_tdata[7:0], v.exp_st);
    end
    recv_cpl(v.cstall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h01, 8'h5A, 32'hDEADBEEF, 8'h00, 8'h5A, 32'h12345678, 3, 5, 1'b1, 8'h00};
    vecs[1] = '{8'h7F, 8'h11, 32'hCAFEF00D, 8'h00, 8'h00, 32'h0,        0, 2, 1'b0, 8'h80};
    vecs[2] = '{8'h02, 8'hA5, 32'h00000000, 8'h00, 8'hA5, 32'hFFFFFFFF, 0, 0, 1'b1, 8'h00};
    vecs[3] = '{8'h03, 8'hFF, 32'hFFFFFFFF, 8'h07, 8'h3C, 32'h00000001, 1, 1, 1'b1, 8'h07};
    vecs[4] = '{8'h00, 8'h22, 32'h00000001, 8'h00, 8'h00, 32'h0,        0, 0, 1'b0, 8'h80};
    vecs[5] = '{8'h04, 8'h33, 32'h00000002, 8'h00, 8'h00, 32'h0,        0, 1, 1'b0, 8'h80};
    vecs[6] = '{8'hFF, 8'h00, 32'h80000000, 8'h00, 8'h00, 32'h0,        0, 0, 1'b0, 8'h80};

    aresetn            = 1'b1;
    bus.cmd_tvalid     = 1'b1;
    bus.cmd_tdata      = pack3(8'h01, 8'h01, 32'h0000CAFE);
    bus.itf_ready      = 1'b0;
    bus.eng_cpl_valid  = 1'b0;
    bus.eng_cpl_status = '0;
    bus.eng_cpl_token  = '0;
    bus.eng_cpl_data   = '0;
    bus.cpl_tready     = 1'b0;

    // Reset with a command already offered: nothing may be taken during reset.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_itf_valid", bus.itf_valid, 0);
      chk("rst_cpl_tvalid", bus.cpl_tvalid, 0);
      chk("rst_eng_cpl_ready", bus.eng_cpl_ready, 0);
      chk("rst_itf_cmd", bus.itf_cmd, 0);
      chk("rst_cpl_tdata", bus.cpl_tdata, 0);
    end
    aresetn = 1'b0;
    chk("rel_cmd_tready", bus.cmd_tready, 1);
    tick();
    bus.cmd_tvalid = 1'b0;
    issue_accept(8'h01, 8'h01, 32'h0000CAFE, 0);
    eng_complete(8'h00, 8'h01, 32'h0000BEEF);
    recv_cpl(0);

    // Table-driven transactions.
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back SEARCH then DELETE with cmd_tvalid held high.
    chk("b2b_ready0", bus.cmd_tready, 1);
    bus.cmd_tvalid = 1'b1;
    bus.cmd_tdata  = pack3(8'h02, 8'h44, 32'h00001111);
    tick();
    bus.cmd_tdata  = pack3(8'h03, 8'h55, 32'h00002222);
    issue_accept(8'h02, 8'h44, 32'h00001111, 1);
    chk("b2b_blocked_wait", bus.cmd_tready, 0);
    eng_complete(8'h00, 8'h44, 32'hAAAA0001);
    recv_cpl(2);
    tick();
    bus.cmd_tvalid = 1'b0;
    bus.cmd_tdata  = '0;
    issue_accept(8'h03, 8'h55, 32'h00002222, 0);
    eng_complete(8'h00, 8'h55, 32'hBBBB0002);
    recv_cpl(0);

    // Reset while waiting on the engine: late completion must be ignored.
    send_cmd(8'h01, 8'h66, 32'h13572468, 1'b1);
    issue_accept(8'h01, 8'h66, 32'h13572468, 0);
    chk("wait_eng_ready", bus.eng_cpl_ready, 1);
    aresetn = 1'b1;
    tick();
    aresetn = 1'b0;
    chk("mid_rst_cmd_tready", bus.cmd_tready, 1);
    chk("mid_rst_eng_ready", bus.eng_cpl_ready, 0);
    chk("mid_rst_itf_data", bus.itf_data, 0);
    bus.eng_cpl_valid  = 1'b1;
    bus.eng_cpl_status = 8'h00;
    bus.eng_cpl_token  = 8'h66;
    bus.eng_cpl_data   = 32'hDEAD0066;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stale_eng_ready", bus.eng_cpl_ready, 0);
      chk("stale_cpl_tvalid", bus.cpl_tvalid, 0);
      chk("stale_cpl_tdata", bus.cpl_tdata, 0);
    end
    bus.eng_cpl_valid = 1'b0;
    chk("sb_empty", sb_q.size(), 0);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bst_cmd_interface.md
Name: bst_cmd_interface

Overview:
- Command front-end of the BST accelerator, between the external AXI4-Stream command/completion ports and the BST engine.
- Accepts one command beat, splits it into opcode, token and payload, and rejects illegal opcodes locally.
- Forwards legal commands to the engine, waits for the engine's completion, and returns it as one AXI4-Stream completion beat.
- At most one command is outstanding, so completions always return in command order.

Parameters:
- TOKEN_WIDTH, 8: width of the token (key) field.
- PAYLOAD_WIDTH, 32: width of the payload field.
- AXI4S_WIDTH, 128: width of cmd_tdata and cpl_tdata. Elaboration fails if TOKEN_WIDTH+PAYLOAD_WIDTH+8 > AXI4S_WIDTH.

Ports:
- aclk  in  1  single clock; all logic is on the rising edge.
- aresetn  in  1  reset, synchronous and active-high (asserted = 1) despite the name.
- cmd_tvalid  in  1  command beat valid.
- cmd_tready  out  1  command beat accepted.
- cmd_tdata  in  AXI4S_WIDTH  command beat: [7:0] opcode, [TOKEN_WIDTH+7:8] token, next PAYLOAD_WIDTH bits payload; upper bits ignored.
- itf_valid  out  1  command valid to engine.
- itf_ready  in  1  engine accepts command.
- itf_cmd  out  8  opcode.
- itf_token  out  TOKEN_WIDTH  token.
- itf_data  out  PAYLOAD_WIDTH  payload.
- eng_cpl_valid  in  1  engine completion valid.
- eng_cpl_ready  out  1  completion accepted from engine.
- eng_cpl_status  in  8  engine status.
- eng_cpl_token  in  TOKEN_WIDTH  engine token.
- eng_cpl_data  in  PAYLOAD_WIDTH  engine data.
- cpl_tvalid  out  1  completion beat valid.
- cpl_tready  in  1  completion beat accepted.
- cpl_tdata  out  AXI4S_WIDTH  completion beat: [7:0] status, then token, then data, upper bits 0.

Behaviour:
- Opcodes: 0x01 INSERT, 0x02 SEARCH, 0x03 DELETE. Every other value is illegal.
- Status codes: 0x00 OK (engine-defined, passed through unchanged); 0x80 ILLEGAL_CMD (generated locally).
- FSM states: IDLE, ISSUE, WAIT_CPL, SEND_CPL. Reset state is IDLE.
- IDLE:
  - cmd_tready=1; all other valids and readies are 0.
  - On a cmd_tvalid&cmd_tready handshake, register opcode, token and payload.
  - Legal opcode: go to ISSUE.
  - Illegal opcode: load completion register with status 0x80, the received token and data 0, then go to SEND_CPL. The engine never sees the command.
- ISSUE:
  - itf_valid=1, with itf_cmd, itf_token and itf_data held stable from the registered fields.
  - On itf_ready, go to WAIT_CPL.
  - Latency: a command accepted at cycle N gives itf_valid at N+1.
- WAIT_CPL:
  - eng_cpl_ready=1.
  - On eng_cpl_valid, register status, token and data, then go to SEND_CPL.
  - Latency: a completion accepted at M gives cpl_tvalid at M+1.
- SEND_CPL:
  - cpl_tvalid=1 with cpl_tdata stable until cpl_tready.
  - On the handshake, go to IDLE. cmd_tready rises the next cycle.
- cmd_tready is 0 in every state except IDLE. Backpressure is total while a command is in flight.
- eng_cpl_valid outside WAIT_CPL is ignored. eng_cpl_ready=0 there, so no data is lost.
- Width rules:
  - Fields are zero-extended into cpl_tdata.
  - cpl_tdata bits above TOKEN_WIDTH+PAYLOAD_WIDTH+8 are always 0.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset (any state, including mid-handshake):
  - Next cycle: IDLE; cmd_tready=1; itf_valid=0, eng_cpl_ready=0, cpl_tvalid=0.
  - itf_cmd, itf_token, itf_data and cpl_tdata are 0.
  - Any in-flight command or completion is discarded.
- Valid outputs never drop without the matching ready (AXI-Stream stability rule).

Decomposition:
- Shared package bster_pkg:
  - opcode constants (INSERT, SEARCH, DELETE).
  - status constants (OK, ILLEGAL_CMD).
  - FSM state enum.
  - cmd/cpl field offset localparams as functions of TOKEN_WIDTH and PAYLOAD_WIDTH.
- Single module. No sub-module is needed, since the FSM plus field registers stay within about 200 lines.

Test Plan:
- Reset with cmd_tvalid=1 held → cmd_tready=1 the cycle after release; itf_valid, cpl_tvalid and eng_cpl_ready are 0 during reset.
- INSERT cmd_tdata {payload 0xDEADBEEF, token 0x5A, opcode 0x01} → next cycle itf_valid=1 with itf_cmd=0x01, itf_token=0x5A, itf_data=0xDEADBEEF. Hold itf_ready=0 for 3 cycles: all values stable and cmd_tready=0.
- Engine completion status 0x00, token 0x5A, data 0x12345678 → cpl_tvalid next cycle with cpl_tdata[7:0]=0x00, [15:8]=0x5A, [47:16]=0x12345678, upper bits 0. Hold cpl_tready=0 for 5 cycles: stable.
- Opcode 0x7F, token 0x11 → no itf_valid; cpl_tdata status 0x80, token 0x11, data 0; cmd_tready returns one cycle after cpl handshake.
- Back-to-back SEARCH then DELETE with cmd_tvalid held high → second command is accepted only after the first completion handshake; completion order is preserved.
- Assert aresetn while in WAIT_CPL → FSM returns to IDLE; a later eng_cpl_valid is ignored (eng_cpl_ready=0) and no stale completion is emitted.
